operand_issue: RTL

- Upstream neighbour of the per-operation execute units (Copy, Add, Sub, etc.) in the 4-bit datapath.
- Holds the register file and accepts one instruction at a time over a valid/ready handshake.
- Reads both source registers, drives a one-hot enable plus the Rd1/Rd2 operand values for exactly one issue cycle, then waits for the execute result and writes it back to the destination register.

---
 rtl/operand_issue.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/operand_issue.sv
// Register file and single-issue operand sequencer feeding the execute units.
// Optional retire counter is enabled by defining ISSUE_RETIRE_CNT_EN.
module operand_issue #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned WB_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [7:0]        op_en,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
`ifdef ISSUE_RETIRE_CNT_EN
  output logic [7:0]        retire_cnt,
`endif
  output logic              busy
);

  localparam int unsigned EN_W  = 8;
  localparam int unsigned CNT_W = 8;
  localparam logic [2:0]  OP_LOADI = 3'd0;
  localparam logic [2:0]  OP_NOP   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   regs_d [NREGS];
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic [EN_W-1:0]     op_en_q, op_en_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
`ifdef ISSUE_RETIRE_CNT_EN
  logic [7:0]          retire_q, retire_d;
`endif

  // Next-state, register-file writes and registered outputs
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    op_en_d = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef ISSUE_RETIRE_CNT_EN
    retire_d = retire_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          if (instr_op == OP_LOADI) begin
            regs_d[instr_rd] = instr_imm;
`ifdef ISSUE_RETIRE_CNT_EN
            retire_d = retire_q + 8'(1);
`endif
          end else if (instr_op != OP_NOP) begin
            state_d = S_ISSUE;
            rd_d    = instr_rd;
            rd1_d   = regs_q[instr_rs1];
            rd2_d   = regs_q[instr_rs2];
            op_en_d = EN_W'(1) << instr_op;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WB;
        cnt_d   = '0;
      end
      S_WB: begin
        if (wb_valid) begin
          regs_d[rd_q] = wb_data;
          state_d      = S_IDLE;
`ifdef ISSUE_RETIRE_CNT_EN
          retire_d = retire_q + 8'(1);
`endif
        end else if (cnt_q == CNT_W'(WB_TIMEOUT - 1)) begin
          // Execute unit never answered: abandon without writing
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      op_en_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ISSUE_RETIRE_CNT_EN
      retire_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      op_en_q <= op_en_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef ISSUE_RETIRE_CNT_EN
      retire_q <= retire_d;
`endif
    end
  end

  assign instr_ready = ready_q;
  assign op_en       = op_en_q;
  assign rd1         = rd1_q;
  assign rd2         = rd2_q;
  assign wb_err      = err_q;
  assign busy        = busy_q;
`ifdef ISSUE_RETIRE_CNT_EN
  assign retire_cnt  = retire_q;
`endif

endmodule
